race_sequencer: RTL and testbench

Top-level game controller for the four-player red-light race. It takes a start/abort request and the round's click and step settings, and runs a countdown before each race. During the race it holds the race datapath in reset or releases it, and paces the red light with timed toggle pulses. It watches the round-robin player status stream to detect the end of the race and report the winner.

---
 rtl/race_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_race_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// race_sequencer: four-player red-light race controller.
// Runs the pre-race countdown, holds or releases the race datapath and
// paces the red light with toggle pulses. It watches the player status
// stream and reports the winner, or reports a timeout.
// Optional feature macro RANDOM_GREEN_EN: the green dwell gets an
// LFSR-random extension. Without it the green dwell is fixed at GREEN_MIN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        race request levels (abort has priority)
//   cfg_clicks/steps    round settings, latched on start
//   light               light code from the red-light unit (2'b10 = red)
//   sel, status         round-robin player status sample
//   game_rst            reset to the race datapath
//   max_clicks/steps    latched settings
//   red_toggle          one-cycle toggle pulse to the red-light unit
//   phase, cd_value     controller phase and countdown value
//   resolved            per-player finished-or-eliminated flags
//   winner(_valid)      first-place player
//   timed_out           race ended by timeout
module race_sequencer #(
  parameter int COUNTDOWN_CYCLES = 16,
  parameter int GREEN_MIN        = 32,
  parameter int GREEN_SPAN       = 32,
  parameter int RED_CYCLES       = 24,
  parameter int SETTLE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] cfg_clicks,
  input  logic [3:0] cfg_steps,
  input  logic [1:0] light,
  input  logic [1:0] sel,
  input  logic [3:0] status,
  output logic       game_rst,
  output logic [3:0] max_clicks,
  output logic [3:0] max_steps,
  output logic       red_toggle,
  output logic [1:0] phase,
  output logic [1:0] cd_value,
  output logic [3:0] resolved,
  output logic [1:0] winner,
  output logic       winner_valid,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    RUN       = 2'b10,
    DONE      = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    LWAIT  = 2'b00,
    LPULSE = 2'b01,
    LACK   = 2'b10
  } lstate_t;

  localparam int TW = (COUNTDOWN_CYCLES > 1) ?
                      $clog2(COUNTDOWN_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int RW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GMAX = GREEN_MIN + GREEN_SPAN - 1;
  localparam int DMAX = (GMAX > RED_CYCLES) ? GMAX : RED_CYCLES;
  localparam int DW = $clog2(DMAX + 1);

  localparam logic [3:0] ST_RACING = 4'b1000;
  localparam logic [3:0] ST_FIRST  = 4'b1001;
  localparam logic [1:0] RED       = 2'b10;

  phase_t        state_q, state_d;
  lstate_t       lst_q, lst_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    cd_q, cd_d;
  logic [3:0]    clicks_q, clicks_d;
  logic [3:0]    steps_q, steps_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [RW-1:0] timer_q, timer_d;
  logic [3:0]    res_q, res_d;
  logic [1:0]    win_q, win_d;
  logic          wvalid_q, wvalid_d;
  logic          tout_q, tout_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    snap_q, snap_d;
  logic [2:0]    ack_q, ack_d;
  logic [DW-1:0] green;
  logic          settled;

`ifdef RANDOM_GREEN_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, free-running
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0],
                      lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign green = DW'(GREEN_MIN) +
                 DW'(lfsr & 8'(GREEN_SPAN - 1));
`else
  assign green = DW'(GREEN_MIN);
`endif

  assign settled = (settle_q == SW'(SETTLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lst_q    <= LWAIT;
      tick_q   <= '0;
      cd_q     <= '0;
      clicks_q <= '0;
      steps_q  <= '0;
      settle_q <= '0;
      timer_q  <= '0;
      res_q    <= '0;
      win_q    <= '0;
      wvalid_q <= 1'b0;
      tout_q   <= 1'b0;
      dwell_q  <= '0;
      snap_q   <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      lst_q    <= lst_d;
      tick_q   <= tick_d;
      cd_q     <= cd_d;
      clicks_q <= clicks_d;
      steps_q  <= steps_d;
      settle_q <= settle_d;
      timer_q  <= timer_d;
      res_q    <= res_d;
      win_q    <= win_d;
      wvalid_q <= wvalid_d;
      tout_q   <= tout_d;
      dwell_q  <= dwell_d;
      snap_q   <= snap_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lst_d    = lst_q;
    tick_d   = tick_q;
    cd_d     = cd_q;
    clicks_d = clicks_q;
    steps_d  = steps_q;
    settle_d = settle_q;
    timer_d  = timer_q;
    res_d    = res_q;
    win_d    = win_q;
    wvalid_d = wvalid_q;
    tout_d   = tout_q;
    dwell_d  = dwell_q;
    snap_d   = snap_q;
    ack_d    = ack_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = COUNTDOWN;
          clicks_d = cfg_clicks;
          steps_d  = cfg_steps;
          cd_d     = 2'd3;
          tick_d   = '0;
          settle_d = '0;
          timer_d  = '0;
          res_d    = '0;
          wvalid_d = 1'b0;
          tout_d   = 1'b0;
        end
      end

      COUNTDOWN: begin
        if (tick_q == TW'(COUNTDOWN_CYCLES - 1)) begin
          tick_d = '0;
          if (cd_q == 2'd0) begin
            // light pacing starts on a green load
            state_d = RUN;
            lst_d   = LWAIT;
            dwell_d = green;
            ack_d   = '0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      RUN: begin
        // status stream is junk while the datapath leaves reset
        if (!settled) begin
          settle_d = settle_q + SW'(1);
        end else begin
          if (status != ST_RACING)
            res_d[sel] = 1'b1;
          if (status == ST_FIRST && !wvalid_q) begin
            win_d    = sel;
            wvalid_d = 1'b1;
          end
        end

        if (timer_q != RW'(TIMEOUT_CYCLES - 1))
          timer_d = timer_q + RW'(1);

        if (res_q == 4'hF) begin
          state_d = DONE;
        end else if (timer_q == RW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          tout_d  = 1'b1;
        end

        unique case (lst_q)
          LWAIT: begin
            if (dwell_q == '0) lst_d = LPULSE;
            else               dwell_d = dwell_q - DW'(1);
          end
          LPULSE: begin
            snap_d = light;
            ack_d  = '0;
            lst_d  = LACK;
          end
          LACK: begin
            // give up waiting for the light after 8 cycles
            if (light != snap_q || ack_q == 3'd7) begin
              lst_d   = LWAIT;
              dwell_d = (light == RED) ? DW'(RED_CYCLES) : green;
            end else begin
              ack_d = ack_q + 3'd1;
            end
          end
          default: lst_d = LWAIT;
        endcase
      end

      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      lst_d   = LWAIT;
    end
  end

  assign phase        = state_q;
  assign game_rst     = (state_q == IDLE) || (state_q == COUNTDOWN);
  assign max_clicks   = clicks_q;
  assign max_steps    = steps_q;
  assign red_toggle   = (state_q == RUN) && (lst_q == LPULSE);
  assign cd_value     = cd_q;
  assign resolved     = res_q;
  assign winner       = win_q;
  assign winner_valid = wvalid_q;
  assign timed_out    = tout_q;

endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer: directed self-checking bench for race_sequencer.
// Scoreboard queue holds expected status-stream results.
module tb_race_sequencer;

  localparam int CD_CYC  = 16;
  localparam int GREEN   = 32;
  localparam int RED_CYC = 24;
  localparam int SETTLE  = 16;
  localparam int TMO     = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_clicks = 4'd0;
  logic [3:0] cfg_steps = 4'd0;
  logic [1:0] light = 2'b00;
  logic [1:0] sel = 2'd0;
  logic [3:0] status = 4'b1000;
  logic       game_rst;
  logic [3:0] max_clicks;
  logic [3:0] max_steps;
  logic       red_toggle;
  logic [1:0] phase;
  logic [1:0] cd_value;
  logic [3:0] resolved;
  logic [1:0] winner;
  logic       winner_valid;
  logic       timed_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  bit light_auto = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  race_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_clicks   (cfg_clicks),
    .cfg_steps    (cfg_steps),
    .light        (light),
    .sel          (sel),
    .status       (status),
    .game_rst     (game_rst),
    .max_clicks   (max_clicks),
    .max_steps    (max_steps),
    .red_toggle   (red_toggle),
    .phase        (phase),
    .cd_value     (cd_value),
    .resolved     (resolved),
    .winner       (winner),
    .winner_valid (winner_valid),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=%0h expected=queued", obs);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // one clock; the light model flips the light the cycle after a pulse
  task automatic step();
    logic pt;
    pt = red_toggle;
    @(posedge clk);
    #1;
    cyc++;
    if (red_toggle) pulses++;
    if (light_auto && pt)
      light = (light == 2'b10) ? 2'b00 : 2'b10;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_toggle(input string tag, input int budget,
                             output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (red_toggle) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=none expected=pulse in %0d",
             tag, budget);
    end
  endtask

  task automatic go_countdown();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run0;
    int at;
    int at2;
    int p0;
    logic [1:0] sel_s[4];
    logic [3:0] st_s[4];
    logic [3:0] res_s[4];

    sel_s = '{2'd2, 2'd0, 2'd1, 2'd3};
    st_s  = '{4'b1001, 4'b1010, 4'b1011, 4'b0000};
    res_s = '{4'b0100, 4'b0101, 4'b0111, 4'b1111};

    // reset and idle
    steps(3);
    rst = 1'b0;
    chk("rst_phase", phase, 2'b00);
    chk("rst_game_rst", game_rst, 1'b1);
    chk("rst_max_clicks", max_clicks, 4'd0);
    chk("rst_max_steps", max_steps, 4'd0);
    chk("rst_toggle", red_toggle, 1'b0);
    chk("rst_cd", cd_value, 2'd0);
    chk("rst_resolved", resolved, 4'd0);
    chk("rst_winner", winner, 2'd0);
    chk("rst_wvalid", winner_valid, 1'b0);
    chk("rst_timeout", timed_out, 1'b0);
    steps(100);
    chk("idle_pulses", pulses, 0);
    chk("idle_phase", phase, 2'b00);
    chk("idle_game_rst", game_rst, 1'b1);

    // start and countdown
    cfg_clicks = 4'd5;
    cfg_steps  = 4'd9;
    go_countdown();
    chk("cd_phase", phase, 2'b01);
    chk("cd_clicks", max_clicks, 4'd5);
    chk("cd_steps", max_steps, 4'd9);
    chk("cd_value3", cd_value, 2'd3);
    chk("cd_game_rst", game_rst, 1'b1);
    cfg_clicks = 4'hF;
    cfg_steps  = 4'h1;
    steps(CD_CYC);
    chk("cd_value2", cd_value, 2'd2);
    steps(3 * CD_CYC - 1);
    chk("cd_last_phase", phase, 2'b01);
    chk("cd_last_value", cd_value, 2'd0);
    step();
    chk("run_phase", phase, 2'b10);
    chk("run_game_rst", game_rst, 1'b0);
    chk("run_clicks_kept", max_clicks, 4'd5);
    chk("run_steps_kept", max_steps, 4'd9);
    run0 = cyc;

    // light pacing with an acknowledging light model
    light_auto = 1'b1;
    wait_toggle("first_pulse", 60, at);
    chk("first_pulse_delay", at - run0, GREEN + 1);
    wait_toggle("red_pulse", 60, at2);
    chk("red_pulse_gap", at2 - at, RED_CYC + 1 + 2);
    chk("red_light", light, 2'b10);

    // status stream: winner then the rest
    for (int i = 0; i < 4; i++) begin
      sel    = sel_s[i];
      status = st_s[i];
      sb_push("stream_resolved", res_s[i]);
      sb_push("stream_winner", 2'd2);
      sb_push("stream_wvalid", 1'b1);
      step();
      sb_pop(resolved);
      sb_pop(winner);
      sb_pop(winner_valid);
    end
    status = 4'b1000;
    chk("last_flag_phase", phase, 2'b10);
    step();
    chk("done_phase", phase, 2'b11);
    chk("done_timeout", timed_out, 1'b0);
    chk("done_game_rst", game_rst, 1'b0);
    p0 = pulses;
    steps(50);
    chk("done_pulses", pulses - p0, 0);

    // restart from DONE: settle window, LACK timeout, race timeout
    light_auto = 1'b0;
    light = 2'b00;
    go_countdown();
    chk("re_phase", phase, 2'b01);
    chk("re_resolved", resolved, 4'd0);
    chk("re_wvalid", winner_valid, 1'b0);
    chk("re_clicks", max_clicks, 4'hF);
    steps(4 * CD_CYC);
    chk("re_run", phase, 2'b10);
    run0 = cyc;
    sel = 2'd1;
    status = 4'b0000;
    steps(SETTLE);
    status = 4'b1000;
    chk("settle_ignored", resolved, 4'd0);
    wait_toggle("re_first_pulse", 40, at);
    chk("re_first_delay", at - run0, GREEN + 1);
    wait_toggle("lack_pulse", 60, at2);
    chk("lack_gap", at2 - at, 1 + 8 + GREEN + 1);
    while (cyc < run0 + TMO - 1) step();
    chk("pre_tmo_phase", phase, 2'b10);
    chk("pre_tmo_flag", timed_out, 1'b0);
    step();
    chk("tmo_phase", phase, 2'b11);
    chk("tmo_flag", timed_out, 1'b1);
    chk("tmo_wvalid", winner_valid, 1'b0);

    // start + abort together in COUNTDOWN
    go_countdown();
    steps(5);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_phase", phase, 2'b00);
    chk("abort_game_rst", game_rst, 1'b1);
    chk("abort_timeout_clr", timed_out, 1'b0);

    // abort in RUN keeps results
    go_countdown();
    steps(4 * CD_CYC);
    chk("r3_run", phase, 2'b10);
    steps(SETTLE);
    sel = 2'd3;
    status = 4'b0000;
    sb_push("elim_resolved", 4'b1000);
    step();
    sb_pop(resolved);
    status = 4'b1000;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_run_phase", phase, 2'b00);
    chk("abort_run_kept", resolved, 4'b1000);
    chk("abort_run_grst", game_rst, 1'b1);

    // reset mid-race
    go_countdown();
    chk("r4_cleared", resolved, 4'd0);
    steps(4 * CD_CYC);
    chk("r4_grst", game_rst, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_phase", phase, 2'b00);
    chk("mid_rst_grst", game_rst, 1'b1);
    chk("mid_rst_clicks", max_clicks, 4'd0);
    chk("mid_rst_cd", cd_value, 2'd0);
    chk("mid_rst_wvalid", winner_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
